// File: rtl/adc_i2s_deserializer.sv
// I2S receive front end for the microphone ADC: generates sck/wsADC, shifts in one
// channel MSB-first and holds the captured sample in a single-entry valid/ready register.
module adc_i2s_deserializer #(
  parameter int CLK_DIV      = 2,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int CHANNEL      = 0
) (
  input  logic                    hwclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    adc_serial_in,
  output logic                    sck,
  output logic                    wsADC,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] S_MSB    = CNT_W'(1);
  localparam logic [CNT_W-1:0] S_LSB    = CNT_W'(SAMPLE_WIDTH);
  localparam logic             CH_WS    = (CHANNEL != 0);

  logic [DIV_W-1:0]        div_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        bit_cnt_next;
  logic [CNT_W-1:0]        slot_idx;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [SAMPLE_WIDTH-1:0] shift_base;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    div_tc;
  logic                    rise_evt;
  logic                    capture;
  logic                    complete;
  logic                    xfer;

  // rise_evt marks the hwclk cycle right after sck went high, so data is taken
  // while sck is high and the completed word lands one hwclk later.
  always_comb begin
    div_tc       = (div_cnt == DIV_LAST);
    bit_cnt_next = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    slot_idx     = (bit_cnt >= SLOT_LEN) ? bit_cnt - SLOT_LEN : bit_cnt;
    capture      = enable && rise_evt && (wsADC == CH_WS) &&
                   (slot_idx >= S_MSB) && (slot_idx <= S_LSB);
    complete     = capture && (slot_idx == S_LSB);
    shift_base   = (slot_idx == S_MSB) ? '0 : shift_reg;
    word         = SAMPLE_WIDTH'({shift_base, adc_serial_in});
    xfer         = sample_valid && sample_ready;
  end

  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      bit_cnt  <= '0;
      wsADC    <= 1'b0;
      rise_evt <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      bit_cnt  <= '0;
      wsADC    <= 1'b0;
      rise_evt <= 1'b0;
    end else begin
      rise_evt <= div_tc && !sck;
      if (div_tc) begin
        div_cnt <= '0;
        sck     <= ~sck;
        // Frame position and ws advance together on the sck falling edge.
        if (sck) begin
          bit_cnt <= bit_cnt_next;
          wsADC   <= (bit_cnt_next >= SLOT_LEN);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (!enable) begin
      shift_reg <= '0;
    end else if (capture) begin
      shift_reg <= word;
    end
  end

  // A completion may refill the holding register in the same cycle it is drained.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= complete && sample_valid && !sample_ready;
      if (complete && (!sample_valid || sample_ready)) begin
        sample_out   <= word;
        sample_valid <= 1'b1;
      end else if (xfer) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_i2s_deserializer.md
Name: adc_i2s_deserializer

Overview:
- Front-end receive stage for the microphone ADC path. Generates the ADC bit clock and word-select (wsADC), and shifts in adc_serial_in MSB-first, I2S-framed.
- Extracts one channel's sample and presents it on a single-entry valid/ready holding register to the downstream datapath (noise gate / effects / volume).

Parameters:
CLK_DIV, 2, hwclk cycles per sck half-period (>=1)
SLOT_BITS, 32, sck periods per channel slot
SAMPLE_WIDTH, 16, captured bits per sample (1..SLOT_BITS-1)
CHANNEL, 0, captured slot: 0 = left (ws low), 1 = right (ws high)

Ports:
hwclk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  run bit clock and framing when high
adc_serial_in  input  1  serial data from ADC
sck  output  1  ADC bit clock
wsADC  output  1  word select, 0 = left slot, 1 = right slot
sample_out  output  SAMPLE_WIDTH  captured sample, two's complement, MSB-first origin
sample_valid  output  1  holding register full
sample_ready  input  1  downstream accepts when high with sample_valid
overrun  output  1  one-cycle pulse: completed sample dropped

Behaviour:
- Reset (reset=0, asynchronous): sck=0, wsADC=0, sample_out=0, sample_valid=0, overrun=0, divider=0, bit_cnt=0, shift register=0.
- Divider:
  - Counts 0..CLK_DIV-1; at terminal count it wraps and sck toggles.
  - Rise event = cycle sck goes 0->1; fall event = cycle sck goes 1->0.
  - sck period = 2*CLK_DIV hwclk.
- Framing:
  - bit_cnt is 0..2*SLOT_BITS-1 and increments on each fall event, wrapping to 0.
  - wsADC = (bit_cnt >= SLOT_BITS), registered in the same cycle as bit_cnt, so ws changes on sck falling edges.
  - Slot index s = bit_cnt mod SLOT_BITS.
- Capture:
  - On a rise event with wsADC==CHANNEL and 1 <= s <= SAMPLE_WIDTH, shift adc_serial_in into the LSB of the shift register. This gives the I2S one-bit delay after the ws edge.
  - Slot bits s=0 and s>SAMPLE_WIDTH are ignored.
  - The shift register clears on the rise event where s==1 (MSB) before loading.
- Completion: the rise event at s==SAMPLE_WIDTH produces a complete word, available combinationally as {shift[SAMPLE_WIDTH-2:0], adc_serial_in}.
  - If the holding register is empty, or is being consumed this cycle (sample_valid && sample_ready): load sample_out and set sample_valid=1 on the next hwclk edge.
  - Else: keep the old sample_out and sample_valid=1, drop the new word, and pulse overrun=1 for one cycle.
- Handshake:
  - Transfer occurs on a cycle with sample_valid && sample_ready.
  - sample_valid clears next cycle unless a completion occurs in the same cycle.
  - sample_out is stable while sample_valid=1 and not transferred.
- Latency: sample_valid rises 1 hwclk after the completing rise event.
  - With defaults, the rise event with bit_cnt=k occurs at hwclk edge 4k+2 after reset release.
  - The left-sample LSB is therefore at edge 66 and sample_valid=1 from edge 67.
- enable=0:
  - Divider, bit_cnt, sck, wsADC and the shift register are forced to 0 synchronously, aborting any partial sample with no overrun.
  - Holding register and handshake continue to operate.
  - Re-enable starts a fresh frame at bit_cnt=0, left slot.
- Reset mid-frame: immediate return to reset values; any held sample is lost.
- No arithmetic on the data: bits are passed through unaltered, with no sign extension.

Test Plan:
1. Assert reset=0 mid-run with sample_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release with enable=1, the first sck rise is at edge 2 and wsADC=1 at bit_cnt=32.
2. Defaults, ready=1, drive 0xA5C3 MSB-first in left slots 1..16 -> sample_valid=1 at edge 67, sample_out=0xA5C3, single-cycle valid.
3. CHANNEL=0, left slot 0x0001, right slot and left slots 0/17..31 all 1s -> sample_out=0x0001 every frame (256 hwclk).
4. sample_ready=0 across two frames carrying 0x1234 then 0x5678:
   - sample_out stays 0x1234 and overrun pulses once, one cycle, at the second completion.
   - Raising ready afterwards -> transfer of 0x1234, then valid=0.
5. sample_ready raised in the exact cycle the second completion occurs -> 0x1234 consumed, sample_out=0x5678 next cycle, sample_valid stays 1, overrun=0.
6. enable dropped at bit_cnt=8 of a left slot, re-raised 20 cycles later -> sck/wsADC=0 while low, no valid or overrun from the partial word, next full frame yields the correct sample.
